// File: rtl/hex_scroll_pkg.sv
// hex_scroll_pkg: glyph codes, segment lookup, message ROM and FSM states for the scroller
package hex_scroll_pkg;
  typedef enum logic [1:0] {S_RUN, S_PAUSE, S_STEP} state_t;
  localparam logic [3:0] G_O = 4'd0, G_L = 4'd1, G_E = 4'd2, G_G = 4'd3, G_BLANK = 4'd4;
  localparam logic [3:0] G_H = 4'd5, G_I = 4'd6, G_B = 4'd7, G_P = 4'd8, G_C = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // "OLEG HIBPC", element 0 is the first character
  localparam logic [9:0][3:0] MSG_ROM = {G_C, G_P, G_B, G_I, G_H, G_BLANK, G_G, G_E, G_L, G_O};
  function automatic logic [6:0] glyph_seg(input logic [3:0] code);
    case (code)
      G_O:     return 7'h40;
      G_L:     return 7'h47;
      G_E:     return 7'h06;
      G_G:     return 7'h42;
      G_H:     return 7'h09;
      G_I:     return 7'h79;
      G_B:     return 7'h00;
      G_P:     return 7'h0C;
      G_C:     return 7'h46;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/glyph_seg_decoder.sv
// glyph_seg_decoder: 4-bit glyph code to active-low a..g segments
module glyph_seg_decoder
  import hex_scroll_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  assign seg = glyph_seg(code);
endmodule

// File: rtl/hex_scroll_display.sv
// hex_scroll_display: scrolls "OLEG HIBPC" across NUM_DIGITS HEX displays; HEX_SCROLL_BLINK_EN blinks while paused
module hex_scroll_display
  import hex_scroll_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 10,
  parameter int TICK_DIV   = 25_000_000
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [1:0]              SW,
  input  logic                    KEY1,
  output logic [7*NUM_DIGITS-1:0] HEX
);
  localparam int L  = MSG_LEN + NUM_DIGITS;
  localparam int PW = $clog2(L);
  localparam int CW = $clog2(TICK_DIV);
  state_t state, nxt;
  logic [1:0] sw_s1, sw_s2;
  logic key_s1, key_s2, key_s3;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pos;
  logic [7*NUM_DIGITS-1:0] segs;
  logic run, dir, step_ev, tick, adv, counting, blink;
  assign run     = sw_s2[0];
  assign dir     = sw_s2[1];
  assign step_ev = key_s3 & ~key_s2;
  assign tick    = cnt == CW'(TICK_DIV - 1);
  assign adv     = state == S_STEP || (state == S_RUN && tick);
  always_comb begin
    nxt = run ? S_RUN : (state == S_PAUSE && step_ev) ? S_STEP : S_PAUSE;
  end
`ifdef HEX_SCROLL_BLINK_EN
  assign counting = state != S_STEP;
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) blink <= 1'b0;
    else blink <= nxt != S_PAUSE ? 1'b0 : tick ? ~blink : blink;
  end
`else
  assign counting = state == S_RUN;
  assign blink    = 1'b0;
`endif
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= S_PAUSE;
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_s3 <= 1'b1;
      cnt    <= '0;
      pos    <= '0;
      HEX    <= '1;
    end else begin
      state  <= nxt;
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
      key_s1 <= KEY1;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      // restarting on every state change gives a full TICK_DIV period after entering S_RUN
      cnt    <= (nxt != state || !counting || tick) ? '0 : cnt + CW'(1);
      pos    <= !adv ? pos
              : dir ? (pos == '0 ? PW'(L - 1) : pos - PW'(1))
              : (pos == PW'(L - 1) ? '0 : pos + PW'(1));
      HEX    <= blink ? '1 : segs;
    end
  end
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    int idx;
    logic [3:0] code;
    always_comb begin
      idx = int'(pos) + NUM_DIGITS - 1 - d;
      idx = idx >= L ? idx - L : idx;
    end
    assign code = idx < MSG_LEN ? MSG_ROM[idx[3:0]] : G_BLANK;
    glyph_seg_decoder u_dec (.code(code), .seg(segs[7*d +: 7]));
  end
endmodule

// File: tb/tb_hex_scroll_display.sv
// tb_hex_scroll_display: scoreboard bench, every HEX change is popped and checked for value and cycle
module tb_hex_scroll_display;
  typedef struct {logic [27:0] v; int cyc;} exp_t;
  localparam logic [27:0] H_OLEG = {7'h40, 7'h47, 7'h06, 7'h42};
  localparam logic [27:0] H_LEGX = {7'h47, 7'h06, 7'h42, 7'h7F};
  localparam logic [27:0] H_XOLE = {7'h7F, 7'h40, 7'h47, 7'h06};
  localparam logic [27:0] H_XXOL = {7'h7F, 7'h7F, 7'h40, 7'h47};
  localparam logic [27:0] H_ALL1 = '1;
  logic clk = 1'b0, resetn = 1'b0, key1 = 1'b1, mon_en = 1'b1;
  logic [1:0] sw = 2'b00;
  logic [27:0] hex, last = '1;
  logic [6:0] glyph [0:9] = '{7'h40, 7'h47, 7'h06, 7'h42, 7'h7F, 7'h09, 7'h79, 7'h00, 7'h0C, 7'h46};
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hex_scroll_display #(.NUM_DIGITS(4), .MSG_LEN(10), .TICK_DIV(4)) dut (
    .CLOCK_50(clk), .resetn(resetn), .SW(sw), .KEY1(key1), .HEX(hex)
  );

  function automatic logic [27:0] win(input int p);
    logic [27:0] r = '0;
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (p + k) % 14;
      r = {r[20:0], i < 10 ? glyph[i] : 7'h7F};
    end
    return r;
  endfunction

  task automatic push(input logic [27:0] v, input int c);
    q.push_back('{v, c});
  endtask

  task automatic chk(input string name, input logic [27:0] got, input logic [27:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && hex !== last) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL hex_unexpected got %h@%0d expected no change", hex, cyc);
        end else begin
          e = q.pop_front();
          if (hex !== e.v || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL hex_seq got %h@%0d expected %h@%0d", hex, cyc, e.v, e.cyc);
          end
        end
      end
      last = hex;
    end
  endtask

  initial begin
    int c;
    logic [27:0] st_exp [4];
    logic [3:0] dirs;
    st_exp = '{H_XOLE, H_XXOL, H_XOLE, H_OLEG};
    dirs = 4'b0011;
    fork
      monitor();
    join_none
    step(3);
    chk("reset_hex", hex, H_ALL1);
`ifdef HEX_SCROLL_BLINK_EN
    c = cyc;
    resetn = 1'b1;
    push(H_OLEG, c + 1);
    push(H_ALL1, c + 5);
    push(H_OLEG, c + 9);
    push(H_ALL1, c + 13);
    push(H_OLEG, c + 17);
    step(18);
    drain(4);
    mon_en = 1'b0;
    key1 = 1'b0;
    step(3);
    key1 = 1'b1;
    for (int n = 0; n < 30 && hex !== H_XOLE; n++) @(negedge clk);
    chk("blink_step", hex, H_XOLE);
`else
    push(H_OLEG, -1);
    resetn = 1'b1;
    step(6);
    drain(4);
    c = cyc;
    sw = 2'b01;
    push(H_LEGX, c + 8);
    for (int k = 2; k <= 15; k++) push(k == 14 ? H_OLEG : win(k % 14), c + 4 + 4 * k);
    step(61);
    sw = 2'b00;
    drain(20);
    step(8);
    c = cyc;
    sw = 2'b01;
    push(win(2), c + 8);
    push(win(3), c + 12);
    push(win(4), c + 16);
    step(9);
    key1 = 1'b0;
    step(3);
    key1 = 1'b1;
    step(6);
    push(H_ALL1, c + 18);
    resetn = 1'b0;
    sw = 2'b00;
    #1;
    chk("async_reset", hex, H_ALL1);
    step(1);
    resetn = 1'b1;
    push(H_OLEG, -1);
    step(6);
    drain(4);
    sw = 2'b10;
    step(4);
    for (int i = 0; i < 4; i++) begin
      sw = {dirs[i], 1'b0};
      step(4);
      c = cyc;
      key1 = 1'b0;
      push(st_exp[i], c + 5);
      step(3);
      key1 = 1'b1;
      step(8);
      drain(4);
    end
    c = cyc;
    sw = 2'b01;
    key1 = 1'b0;
    push(H_LEGX, c + 8);
    step(3);
    key1 = 1'b1;
    step(2);
    sw = 2'b00;
    step(10);
    drain(4);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
